// File: rtl/ram_pc_uart_tx.sv
// ram_pc_uart_tx
//
// Return path of the image processor. After a start request it reads the
// pixel RAM sequentially from address 0 and sends each byte to the PC as a
// UART 8N1 frame. When the last byte's stop bit is complete it pulses done.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   reset         synchronous, active-high reset
//   start         begins a transfer, only looked at while idle
//   ram_addr      RAM read address, held steady while a byte is on the line
//   ram_rd_en     one-cycle read strobe per byte (synchronous RAM, latency 1)
//   ram_rd_data   RAM read data, valid the cycle after ram_rd_en
//   tx            registered UART serial output, idles high
//   busy          high from the accepted start until done
//   done          one-cycle pulse after the final stop bit
//   byte_cnt_led  top 8 bits of ram_addr, for progress LEDs
module ram_pc_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_BYTES    = 65536
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rd_en,
    input  logic [7:0]            ram_rd_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            byte_cnt_led
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        STOP,
        NEXT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [2:0]        next_bit;
    logic [7:0]        shift_reg;
    logic              baud_last;
    logic              last_addr;
    logic              next_tx;

    // The terminal compare is made on the current address, before any
    // increment, so a full 2^ADDR_WIDTH transfer ends without wrapping.
    assign baud_last    = (baud_cnt == BAUD_LAST);
    assign last_addr    = (ram_addr == LAST_ADDR);
    assign byte_cnt_led = ram_addr[ADDR_WIDTH-1 -: 8];

    // Next-state logic and the decoded outputs. The value tx will take on the
    // next cycle is worked out here from the next state and next bit index,
    // so that the tx flop lines up exactly with the state it belongs to.
    always_comb begin
        next_state = state;
        next_bit   = bit_cnt;
        ram_rd_en  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        next_tx    = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                ram_rd_en  = 1'b1;
                next_state = LATCH;
            end
            LATCH: begin
                next_state = START;
            end
            START: begin
                if (baud_last) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_cnt == 3'd7) begin
                        next_state = STOP;
                    end else begin
                        next_bit = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    next_state = NEXT;
                end
            end
            NEXT: begin
                if (last_addr) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        case (next_state)
            START:   next_tx = 1'b0;
            DATA:    next_tx = shift_reg[next_bit];
            default: next_tx = 1'b1;
        endcase
    end

    // State, timing counters, data and address registers. The baud counter
    // is the only timebase and restarts on every state entry, so each bit is
    // exactly CLKS_PER_BIT cycles with no accumulated drift. The bit counter
    // also clears on every state change, which leaves it at zero on DATA
    // entry. Read data is captured only in LATCH, the one cycle it is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ram_addr  <= '0;
            tx        <= 1'b1;
        end else begin
            state <= next_state;
            tx    <= next_tx;

            if (next_state != state || baud_last) begin
                baud_cnt <= '0;
            end else if (state == START || state == DATA || state == STOP) begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (next_state != state) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= next_bit;
            end

            if (state == LATCH) begin
                shift_reg <= ram_rd_data;
            end

            if (state == IDLE && start) begin
                ram_addr <= '0;
            end else if (state == NEXT && !last_addr) begin
                ram_addr <= ram_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_pc_uart_tx.sv
// tb_ram_pc_uart_tx
//
// Bench for ram_pc_uart_tx. Two instances share clock and reset: inst 0 is a
// three-byte transfer (A5, 3C, FF), inst 1 a two-byte transfer (01, 80),
// both at four clocks per bit. Only one instance is active at a time, so a
// single set of expectation queues, tagged with the instance number, serves
// both. The stimulus pushes the expected frames, read addresses and done
// cycles; a monitor decodes tx and pops them as the DUT produces them.
module tb_ram_pc_uart_tx;

    localparam int CPB         = 4;
    localparam int AW          = 8;
    localparam int BYTE_CYCLES = 10 * CPB + 3;
    localparam int FRAME_LEN   = 10 * CPB;
    localparam int TAG         = 1000000;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          start0 = 1'b0;
    logic          start1 = 1'b0;
    logic [7:0]    rd_data0;
    logic [7:0]    rd_data1;
    wire  [AW-1:0] addr0;
    wire  [AW-1:0] addr1;
    wire           rd_en0;
    wire           rd_en1;
    wire           tx0;
    wire           tx1;
    wire           busy0;
    wire           busy1;
    wire           done0;
    wire           done1;
    wire  [7:0]    led0;
    wire  [7:0]    led1;

    wire  [1:0]    tx_v    = {tx1, tx0};
    wire  [1:0]    busy_v  = {busy1, busy0};
    wire  [1:0]    done_v  = {done1, done0};
    wire  [1:0]    rd_en_v = {rd_en1, rd_en0};

    logic [7:0]    mem0 [0:255];
    logic [7:0]    mem1 [0:255];
    logic [7:0]    exp_bytes0 [0:2] = '{8'hA5, 8'h3C, 8'hFF};
    logic [7:0]    exp_bytes1 [0:1] = '{8'h01, 8'h80};

    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    int            exp_byte_q [$];
    int            exp_addr_q [$];
    int            exp_done_q [$];

    logic [39:0]   frame [2];
    int            frame_pos [2] = '{0, 0};
    logic [1:0]    rd_prev = 2'b00;
    logic [1:0]    done_prev = 2'b00;

    ram_pc_uart_tx #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .NUM_BYTES(3)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .ram_addr(addr0),
        .ram_rd_en(rd_en0), .ram_rd_data(rd_data0), .tx(tx0), .busy(busy0),
        .done(done0), .byte_cnt_led(led0)
    );

    ram_pc_uart_tx #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .NUM_BYTES(2)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .ram_addr(addr1),
        .ram_rd_en(rd_en1), .ram_rd_data(rd_data1), .tx(tx1), .busy(busy1),
        .done(done1), .byte_cnt_led(led1)
    );

    // Free-running clock and a cycle counter used as the time reference for
    // all expected event times.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM models. Outside the cycle after a read strobe the data
    // bus carries random junk, so any sampling outside LATCH corrupts frames.
    always @(posedge clk) begin
        rd_data0 <= rd_en0 ? mem0[addr0] : 8'($urandom);
        rd_data1 <= rd_en1 ? mem1[addr1] : 8'($urandom);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // A complete frame: every bit must hold for CPB samples, the stop bit
    // must be high, and the mid-bit data samples must give the next byte.
    task automatic checkFrame(input int d, input logic [39:0] bits);
        logic       shape_ok;
        logic [7:0] val;
        shape_ok = 1'b1;
        for (int j = 0; j < 10; j++) begin
            for (int k = 1; k < CPB; k++) begin
                if (bits[CPB*j+k] !== bits[CPB*j]) shape_ok = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) val[i] = bits[CPB*(i+1)+CPB/2];
        checkOutput("bit width", int'(shape_ok), 1);
        checkOutput("stop bit", int'(bits[CPB*9+CPB/2]), 1);
        if (exp_byte_q.size() == 0) begin
            checkOutput("pending frames", 0, 1);
        end else begin
            checkOutput("frame byte", d * 256 + int'(val), exp_byte_q.pop_front());
        end
    endtask

    // Monitor: on the falling edge, decode tx frames, check each read strobe
    // against the expected address (and that it lasts one cycle), and check
    // each done pulse against its expected cycle with busy low afterwards.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                frame_pos[d] = 0;
                rd_prev[d]   = 1'b0;
                done_prev[d] = 1'b0;
            end else begin
                if (frame_pos[d] == 0) begin
                    if (busy_v[d] && tx_v[d] == 1'b0) begin
                        frame[d][0]  = 1'b0;
                        frame_pos[d] = 1;
                    end
                end else if (!busy_v[d]) begin
                    frame_pos[d] = 0;
                end else begin
                    frame[d][frame_pos[d]] = tx_v[d];
                    frame_pos[d]++;
                    if (frame_pos[d] == FRAME_LEN) begin
                        checkFrame(d, frame[d]);
                        frame_pos[d] = 0;
                    end
                end

                if (rd_prev[d]) checkOutput("rd_en one cycle", int'(rd_en_v[d]), 0);
                rd_prev[d] = rd_en_v[d];
                if (rd_en_v[d]) begin
                    if (exp_addr_q.size() == 0) begin
                        checkOutput("pending reads", 0, 1);
                    end else begin
                        int ea;
                        ea = exp_addr_q.pop_front();
                        checkOutput("read addr", d * 256 + int'(d == 0 ? addr0 : addr1), ea);
                        checkOutput("led", int'(d == 0 ? led0 : led1), ea % 256);
                    end
                end

                if (done_prev[d]) checkOutput("busy after done", int'(busy_v[d]), 0);
                done_prev[d] = done_v[d];
                if (done_v[d]) begin
                    if (exp_done_q.size() == 0) begin
                        checkOutput("pending done", 0, 1);
                    end else begin
                        checkOutput("done cycle", d * TAG + cyc, exp_done_q.pop_front());
                    end
                end
            end
        end
    end

    // Raises start for instance d at the current falling edge and queues the
    // expected reads, frames and done cycle. With hold set, start stays high
    // and two back-to-back transfers are expected.
    task automatic applyStimulus(input int d, input bit hold, output int c);
        int n;
        int base;
        c = cyc;
        n = (d == 0) ? 3 : 2;
        for (int r = 0; r < (hold ? 2 : 1); r++) begin
            base = c + r * (BYTE_CYCLES * n + 1);
            for (int i = 0; i < n; i++) begin
                exp_addr_q.push_back(d * 256 + i);
                exp_byte_q.push_back(d * 256 + int'(d == 0 ? exp_bytes0[i] : exp_bytes1[i]));
            end
            exp_done_q.push_back(d * TAG + base + BYTE_CYCLES * n);
        end
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        if (!hold) begin
            if (d == 0) start0 = 1'b0; else start1 = 1'b0;
        end
    endtask

    task automatic wait_until_cycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input int d);
        for (int k = 0; k < 1000 && busy_v[d]; k++) @(negedge clk);
        checkOutput("transfer completes", int'(busy_v[d]), 0);
    endtask

    // Directed scenarios, run one after another.
    initial begin
        int         c;
        logic [9:0] seq;

        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        mem0[0] = 8'hA5;
        mem0[1] = 8'h3C;
        mem0[2] = 8'hFF;
        mem1[0] = 8'h01;
        mem1[1] = 8'h80;

        // Reset values.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset tx", int'(tx0), 1);
        checkOutput("reset busy", int'(busy0), 0);
        checkOutput("reset done", int'(done0), 0);
        checkOutput("reset rd_en", int'(rd_en0), 0);
        checkOutput("reset addr", int'(addr0), 0);
        checkOutput("reset led", int'(led0), 0);
        reset = 1'b0;
        @(negedge clk);

        // Three-byte transfer, with a stray start pulse during byte 1.
        $display("[TB] three-byte transfer with start re-pulse");
        applyStimulus(0, 1'b0, c);
        for (int k = 0; k < 20 && tx0 !== 1'b0; k++) @(negedge clk);
        checkOutput("first start bit delay", cyc - c, 3);
        wait_until_cycle(c + BYTE_CYCLES + 10);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checkOutput("addr after re-pulse", int'(addr0), 1);
        checkOutput("busy after re-pulse", int'(busy0), 1);
        wait_idle(0);

        // Byte 0x01: one sample per bit, LSB first, then the stop bit.
        $display("[TB] bit order for byte 0x01");
        applyStimulus(1, 1'b0, c);
        for (int j = 0; j < 10; j++) begin
            wait_until_cycle(c + 3 + CPB * j + CPB / 2);
            seq[j] = tx1;
        end
        checkOutput("0x01 bit sequence", int'(seq), int'(10'b1000000010));
        wait_idle(1);

        // Reset in the middle of byte 1's data bits, then a fresh transfer.
        $display("[TB] reset mid-frame");
        applyStimulus(0, 1'b0, c);
        wait_until_cycle(c + BYTE_CYCLES + 3 + CPB + 10);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("tx after reset", int'(tx0), 1);
        checkOutput("busy after reset", int'(busy0), 0);
        checkOutput("addr after reset", int'(addr0), 0);
        reset = 1'b0;
        exp_byte_q.delete();
        exp_addr_q.delete();
        exp_done_q.delete();
        repeat (200) @(negedge clk);
        applyStimulus(0, 1'b0, c);
        wait_idle(0);

        // Start held high: two complete transfers back to back.
        $display("[TB] start held across done");
        applyStimulus(1, 1'b1, c);
        wait_until_cycle(c + 2 * (2 * BYTE_CYCLES) + 1);
        start1 = 1'b0;
        wait_idle(1);
        repeat (20) @(negedge clk);
        checkOutput("no restart after release", int'(busy1), 0);

        checkOutput("frames left", exp_byte_q.size(), 0);
        checkOutput("reads left", exp_addr_q.size(), 0);
        checkOutput("done pulses left", exp_done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_pc_uart_tx.md
Name: ram_pc_uart_tx

Overview:
- Return path of the image processor: streams a processed image from on-chip pixel RAM to the PC over UART 8N1.
- Counterpart of the PC-to-RAM receive path. Active when the top-level mode controller is in RAM_PC_ACT mode.
- Reads RAM sequentially from address 0, serialises each byte on tx, then pulses done.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range is 2 or more.
- ADDR_WIDTH, 16, RAM address width.
- NUM_BYTES, 65536, bytes per transfer; legal range is 1 to 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a transfer; sampled only in IDLE.
- ram_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_en  out  1  RAM read strobe, one cycle per byte.
- ram_rd_data  in  8  RAM read data, valid the cycle after ram_rd_en (synchronous RAM, latency 1).
- tx  out  1  UART serial output; idle level is high.
- busy  out  1  high from the cycle start is accepted until done.
- done  out  1  one-cycle pulse after the stop bit of the last byte.
- byte_cnt_led  out  8  bits [ADDR_WIDTH-1 -: 8] of the current address, for progress LEDs.

Behaviour:
- Reset (synchronous, priority over all other inputs; takes effect at the next edge):
  - outputs: tx=1, busy=0, done=0, ram_rd_en=0, ram_addr=0, byte_cnt_led=0;
  - state returns to IDLE and the bit counter and baud counter clear;
  - reset mid-frame truncates the frame: tx returns high on the next cycle and no done pulse is produced.
- States: IDLE, FETCH, LATCH, START, DATA, STOP, NEXT.
- IDLE:
  - tx=1, busy=0;
  - start=1 at edge E means: busy=1, ram_addr=0, state=FETCH after E.
- FETCH (1 cycle): ram_rd_en=1; next state LATCH.
- LATCH (1 cycle): shift register loads ram_rd_data; next state START.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles;
  - the first tx=0 cycle is 3 cycles after the start edge for byte 0.
- DATA:
  - 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles;
  - a 3-bit counter selects the bit.
- STOP: tx=1 for exactly CLKS_PER_BIT cycles.
- NEXT (1 cycle):
  - if ram_addr == NUM_BYTES-1: done=1 for this single cycle, busy=0 from the next cycle, state IDLE;
  - otherwise: ram_addr increments, state FETCH;
  - at ADDR_WIDTH with NUM_BYTES = 2^ADDR_WIDTH the terminal compare happens before the increment, so the address never wraps.
- Per-byte period: 10*CLKS_PER_BIT + 3 cycles (FETCH, LATCH, NEXT). The inter-byte gap is 3 idle-high cycles.
- Baud counter:
  - counts 0 to CLKS_PER_BIT-1 within START, DATA and STOP;
  - it is the only timebase and is reset on every state entry, so there is no drift between bits.
- tx is a registered output with no combinational path from the state.
- ram_rd_en is high only in FETCH; it is never asserted in IDLE.
- start while busy=1 is ignored, whether held or pulsed.
- start held high across done starts a new transfer on the first IDLE cycle after done.
- ram_rd_data is sampled only in LATCH; changes at other times have no effect.
- ram_addr holds its value through START, DATA and STOP.
- byte_cnt_led tracks ram_addr combinationally from the register.

Test Plan:
1. CLKS_PER_BIT=4, NUM_BYTES=3, RAM={0xA5,0x3C,0xFF}; pulse start.
   - tx frames decode to A5, 3C, FF in that order; each bit lasts 4 cycles;
   - the first falling edge of tx is 3 cycles after start;
   - done pulses once, 43*3 cycles after start; busy falls on the next cycle.
2. Byte 0x01, CLKS_PER_BIT=4: the tx sequence (1 sample per bit) is 0,1,0,0,0,0,0,0,0,1. This checks LSB-first ordering and the stop bit.
3. Re-pulse start during byte 1 of scenario 1: no restart, ram_addr never returns to 0, output is identical to scenario 1.
4. Assert reset for 1 cycle in the middle of DATA of byte 1:
   - next cycle: tx=1, busy=0, ram_addr=0; no done pulse follows;
   - a later start re-sends from byte 0.
5. Hold start high continuously with NUM_BYTES=2: two complete transfers back-to-back, done pulses twice, address sequence 0,1,0,1.
6. ram_rd_en check: exactly NUM_BYTES one-cycle pulses per transfer, each followed by the LATCH cycle. Changing ram_rd_data outside LATCH does not alter the transmitted data.
